wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback stage of the 5-stage pipeline, directly downstream of the memory/writeback latch.
- Decodes the latched instruction and selects the writeback value: ALU result, load data, exception code or setx target.
- Owns the 32x32 architectural register file, with two combinational read ports for decode.
- Exports its write port to the execute-stage bypass logic.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS) = 5.
- DATA_W, 32, register and datapath width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears the register file.
- o_in  in  DATA_W  latched ALU result; for jal, carries PC+1 from upstream.
- d_in  in  DATA_W  latched load data.
- ins_in  in  32  latched instruction.
- ovf_in  in  1  latched ALU overflow.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  DATA_W  read port 1 data.
- rs2_data  out  DATA_W  read port 2 data.
- wb_we  out  1  a register write is committed this cycle.
- wb_rd  out  5  destination register of that write.
- wb_data  out  DATA_W  value being written.

Behaviour:
- Instruction fields:
  - opcode = ins_in[31:27], rd = [26:22], aluop = [6:2], T = [26:0].
- Writing instructions and their results:
  - R-type (opcode 00000): rd <= o_in.
  - addi (00101): rd <= o_in.
  - lw (01000): rd <= d_in.
  - jal (00011): r31 <= o_in.
  - setx (10101): r30 <= zero-extended T.
- All other opcodes write nothing: sw, j, bne, jr, blt, bex.
- Overflow override, applied when ovf_in=1, replacing destination and data with r30 <= code:
  - R-type add (aluop 00000): code 1.
  - addi: code 2.
  - R-type sub (00001): code 3.
  - R-type mul (00110): code 4.
  - R-type div (00111): code 5.
  - ovf_in on any other instruction is ignored.
- Writes to r0:
  - wb_we deasserts whenever the destination is r0.
  - r0 always reads 0.
  - The nop 0x00000000 therefore commits nothing.
- wb_we, wb_rd and wb_data are combinational from the inputs.
  - When wb_we=0, wb_rd and wb_data are 0.
- The register file updates on the rising edge of clk when wb_we=1.
- Read ports are combinational.
  - Write-through bypass: if wb_we=1 and rsN_addr==wb_rd (nonzero), rsN_data = wb_data in the same cycle.
  - Otherwise rsN_data is the stored value.
  - Both ports may read the same register, including the one being written.
- Latency: a value is visible on a read port in the same cycle it is presented, and stored at the next edge.
- Reset:
  - While reset=1: wb_we=0, wb_rd=0, wb_data=0, rs1_data=0, rs2_data=0.
  - At every edge with reset=1, all registers become 0.
  - Any write pending in a reset cycle is dropped, not deferred.
  - The first edge after reset deasserts commits normally.
- No stall input: the stage writes back whatever the latch presents every cycle. Bubbles arrive as nop.

Decomposition:
- Shared package, also used by decode and execute:
  - opcode constants (ALU, ADDI, SW, LW, J, BNE, JAL, JR, BLT, BEX, SETX);
  - aluop constants (ADD, SUB, AND, OR, SLL, SRA, MUL, DIV);
  - exception codes 1-5;
  - RSTATUS = 30, RA = 31;
  - instruction field bit positions.
- One natural sub-module: wb_decode.
  - Purely combinational: ins_in, o_in, d_in, ovf_in -> we, rd, data.
  - Top level keeps the storage array, reset and bypass read muxes.

Test Plan:
1. Reset and r0 write:
   - Hold reset for 2 cycles, then release -> every address reads 0.
   - Apply R-type add rd=0 with o_in=0xDEADBEEF -> wb_we=0 and r0 still reads 0.
2. ALU and load writes:
   - R-type add rd=5, o_in=0x12345678 -> r5 reads 0x12345678 from the next cycle.
   - lw rd=7, d_in=0xCAFEF00D, o_in=0x100 -> r7 reads 0xCAFEF00D, not 0x100.
3. Overflow codes:
   - add rd=4, ovf_in=1 -> r30=1 and r4 unchanged.
   - Repeat for addi, sub, mul, div -> r30 = 2, 3, 4, 5 respectively.
   - R-type and with ovf_in=1 -> writes rd normally.
4. jal and setx:
   - jal with o_in=0x00000042 -> r31=0x42.
   - setx T=0x7FFFFFF -> r30=0x07FFFFFF.
   - sw, bne, j, bex -> wb_we=0 and no register changes.
5. Bypass:
   - Commit add rd=9, o_in=0xA5A5A5A5 with rs1_addr=rs2_addr=9 in the same cycle -> both ports show 0xA5A5A5A5 before the edge.
   - Same cycle with rs1_addr=10 -> port shows the stored r10.
6. Reset mid-operation:
   - Assert reset in the same cycle as lw rd=3, d_in=0x55 -> r3 reads 0 after reset.
   - Next write after deassert commits.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared ISA constants for decode, execute and writeback
package wb_regfile_pkg;

  localparam int REG_IDX_W = 5;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;
  localparam int T_HI     = 26;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  localparam logic [REG_IDX_W-1:0] RSTATUS = 5'd30;
  localparam logic [REG_IDX_W-1:0] RA      = 5'd31;

  // Exception code reported when the ALU flags overflow; EXC_NONE means ignore it.
  function automatic logic [2:0] ovfCode(input logic [4:0] opcode, input logic [4:0] aluop);
    logic [2:0] code;
    code = EXC_NONE;
    if (opcode == OP_ADDI) begin
      code = EXC_ADDI;
    end else if (opcode == OP_ALU) begin
      case (aluop)
        ALU_ADD: code = EXC_ADD;
        ALU_SUB: code = EXC_SUB;
        ALU_MUL: code = EXC_MUL;
        ALU_DIV: code = EXC_DIV;
        default: code = EXC_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - combinational writeback select: instruction -> write enable, dest, value
module wb_decode
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]          insIn,
  input  logic [DATA_W-1:0]    oIn,
  input  logic [DATA_W-1:0]    dIn,
  input  logic                 ovfIn,
  output logic                 we,
  output logic [REG_IDX_W-1:0] rd,
  output logic [DATA_W-1:0]    data
);

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic [2:0] excCode;

  assign opcode = insIn[OPC_HI:OPC_LO];
  assign aluop  = insIn[ALUOP_HI:ALUOP_LO];

  always_comb begin
    we      = 1'b0;
    rd      = '0;
    data    = '0;
    excCode = ovfIn ? ovfCode(opcode, aluop) : EXC_NONE;
    case (opcode)
      OP_ALU, OP_ADDI: begin
        we   = 1'b1;
        rd   = insIn[RD_HI:RD_LO];
        data = oIn;
      end
      OP_LW: begin
        we   = 1'b1;
        rd   = insIn[RD_HI:RD_LO];
        data = dIn;
      end
      OP_JAL: begin
        we   = 1'b1;
        rd   = RA;
        data = oIn;
      end
      OP_SETX: begin
        we   = 1'b1;
        rd   = RSTATUS;
        data = DATA_W'(insIn[T_HI:0]);
      end
      default: ;
    endcase
    // Overflow redirects the whole write to the status register.
    if (excCode != EXC_NONE) begin
      rd   = RSTATUS;
      data = DATA_W'(excCode);
    end
    if (rd == '0) we = 1'b0;
    if (!we) begin
      rd   = '0;
      data = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage owning the architectural register file
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    o_in,
  input  logic [DATA_W-1:0]    d_in,
  input  logic [31:0]          ins_in,
  input  logic                 ovf_in,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]    rs1_data,
  output logic [DATA_W-1:0]    rs2_data,
  output logic                 wb_we,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_data
);

  logic                 decWe;
  logic [REG_IDX_W-1:0] decRd;
  logic [DATA_W-1:0]    decData;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  wb_decode #(.DATA_W(DATA_W)) u_decode (
    .insIn (ins_in),
    .oIn   (o_in),
    .dIn   (d_in),
    .ovfIn (ovf_in),
    .we    (decWe),
    .rd    (decRd),
    .data  (decData)
  );

  // A write presented during reset is dropped, so the export is gated too.
  assign wb_we   = decWe & ~reset;
  assign wb_rd   = wb_we ? decRd : '0;
  assign wb_data = wb_we ? decData : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign rs1_data = (reset || rs1_addr == '0) ? '0 :
                    (wb_we && rs1_addr == wb_rd) ? wb_data : regs[rs1_addr];
  assign rs2_data = (reset || rs2_addr == '0) ? '0 :
                    (wb_we && rs2_addr == wb_rd) ? wb_data : regs[rs2_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized and directed check of wb_regfile against a reference model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] o_in, d_in, ins_in;
  logic        ovf_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_we;
  logic [4:0]  wb_rd;

  logic [31:0] refRegs [32];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .o_in     (o_in),
    .d_in     (d_in),
    .ins_in   (ins_in),
    .ovf_in   (ovf_in),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int aluop);
    logic [31:0] w;
    w = '0;
    w[31:27] = 5'(op);
    w[26:22] = 5'(rd);
    w[6:2]   = 5'(aluop);
    return w;
  endfunction

  // Reference: what the stage should commit, straight from the instruction rules.
  function automatic void predict(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] d,
                                  input logic ovf, input logic rst,
                                  output logic we, output logic [4:0] rd, output logic [31:0] data);
    int op, al, code;
    op = int'(ins[31:27]);
    al = int'(ins[6:2]);
    we = 1'b0; rd = 5'd0; data = 32'd0; code = 0;
    if (op == 0)       begin we = 1'b1; rd = ins[26:22]; data = o; end
    else if (op == 5)  begin we = 1'b1; rd = ins[26:22]; data = o; end
    else if (op == 8)  begin we = 1'b1; rd = ins[26:22]; data = d; end
    else if (op == 3)  begin we = 1'b1; rd = 5'd31; data = o; end
    else if (op == 21) begin we = 1'b1; rd = 5'd30; data = {5'd0, ins[26:0]}; end
    if (ovf && op == 5) code = 2;
    if (ovf && op == 0 && al == 0) code = 1;
    if (ovf && op == 0 && al == 1) code = 3;
    if (ovf && op == 0 && al == 6) code = 4;
    if (ovf && op == 0 && al == 7) code = 5;
    if (code != 0) begin rd = 5'd30; data = 32'(code); end
    if (rd == 5'd0 || rst) we = 1'b0;
    if (!we) begin rd = 5'd0; data = 32'd0; end
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a, input logic rst, input logic we,
                                          input logic [4:0] rd, input logic [31:0] data);
    if (rst || a == 5'd0) return 32'd0;
    if (we && a == rd) return data;
    return refRegs[a];
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] d,
                       input logic ovf, input logic rst, input logic [4:0] a1, input logic [4:0] a2);
    logic we;
    logic [4:0] rd;
    logic [31:0] data;
    @(negedge clk);
    ins_in = ins; o_in = o; d_in = d; ovf_in = ovf; reset = rst;
    rs1_addr = a1; rs2_addr = a2;
    predict(ins, o, d, ovf, rst, we, rd, data);
    #1;
    check("wb_we", {31'd0, wb_we}, {31'd0, we});
    check("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    check("wb_data", wb_data, data);
    check($sformatf("rs1[%0d]", a1), rs1_data, expRead(a1, rst, we, rd, data));
    check($sformatf("rs2[%0d]", a2), rs2_data, expRead(a2, rst, we, rd, data));
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    else if (we) refRegs[rd] = data;
  endtask

  initial begin
    logic [31:0] ins;
    int op;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'hx;
    reset = 1'b1; ins_in = '0; o_in = '0; d_in = '0; ovf_in = 1'b0;
    rs1_addr = '0; rs2_addr = '0;

    cycle(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd1, 5'd2);
    cycle(mk(0, 5, 0), 32'h1111_1111, 32'd0, 1'b0, 1'b1, 5'd5, 5'd31);
    for (int i = 0; i < 16; i++) cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'(2 * i), 5'(2 * i + 1));
    cycle(mk(0, 0, 0), 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);

    cycle(mk(0, 5, 0), 32'h1234_5678, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd5);
    cycle(mk(8, 7, 0), 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd1, 5'd2);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd7, 5'd5);

    cycle(mk(0, 4, 0), 32'h0000_0044, 32'd0, 1'b0, 1'b0, 5'd4, 5'd30);
    cycle(mk(0, 4, 0), 32'h8000_0000, 32'd0, 1'b1, 1'b0, 5'd4, 5'd30);
    cycle(mk(5, 4, 0), 32'h8000_0001, 32'd0, 1'b1, 1'b0, 5'd4, 5'd30);
    cycle(mk(0, 4, 1), 32'h8000_0002, 32'd0, 1'b1, 1'b0, 5'd4, 5'd30);
    cycle(mk(0, 4, 6), 32'h8000_0003, 32'd0, 1'b1, 1'b0, 5'd4, 5'd30);
    cycle(mk(0, 4, 7), 32'h8000_0004, 32'd0, 1'b1, 1'b0, 5'd4, 5'd30);
    cycle(mk(0, 6, 2), 32'h0000_0066, 32'd0, 1'b1, 1'b0, 5'd6, 5'd30);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd6, 5'd30);

    cycle(mk(3, 0, 0), 32'h0000_0042, 32'd0, 1'b0, 1'b0, 5'd31, 5'd30);
    cycle({5'b10101, 27'h7FF_FFFF}, 32'd0, 32'd0, 1'b0, 1'b0, 5'd31, 5'd30);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd31, 5'd30);
    cycle(mk(7, 5, 0), 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b1, 1'b0, 5'd5, 5'd7);
    cycle(mk(2, 5, 0), 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b1, 1'b0, 5'd5, 5'd7);
    cycle(mk(1, 5, 0), 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b0, 1'b0, 5'd5, 5'd7);
    cycle(mk(22, 5, 0), 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b0, 1'b0, 5'd5, 5'd7);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd7);

    cycle(mk(0, 10, 0), 32'h1010_1010, 32'd0, 1'b0, 1'b0, 5'd10, 5'd10);
    cycle(mk(0, 9, 0), 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, 5'd9, 5'd9);
    cycle(mk(0, 9, 0), 32'h5A5A_5A5A, 32'd0, 1'b0, 1'b0, 5'd10, 5'd9);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9, 5'd10);

    cycle(mk(8, 3, 0), 32'd0, 32'h0000_0055, 1'b0, 1'b1, 5'd3, 5'd9);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd9);
    cycle(mk(0, 3, 0), 32'h0000_0077, 32'd0, 1'b0, 1'b0, 5'd3, 5'd31);
    cycle(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd31);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0, 1: op = 0;
        2:    op = 5;
        3:    op = 8;
        4:    op = 3;
        5:    op = 21;
        default: op = int'($urandom_range(0, 31));
      endcase
      ins = $urandom;
      ins[31:27] = 5'(op);
      if ($urandom_range(0, 1) == 1) ins[6:2] = 5'($urandom_range(0, 7));
      cycle(ins, $urandom, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0),
            5'($urandom), 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
